// File: rtl/sprite_mapper.sv
// Sprite overlay pipeline: maps screen pixels to sprite ROM addresses and muxes the palette colour
// over the background. Position, flip and animation frame are latched only at vsync.
module sprite_mapper #(
  parameter int unsigned IMG_W           = 14,
  parameter int unsigned IMG_H           = 14,
  parameter int unsigned SCALE_LOG2      = 1,
  parameter int unsigned NUM_FRAMES      = 4,
  parameter int unsigned FRAME_TICKS     = 8,
  parameter int unsigned IDX_W           = 2,
  parameter int unsigned TRANSPARENT_IDX = 0,
  parameter int unsigned ADDR_W          = 10
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              vsync_pulse,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              flip_h,
  input  logic              anim_en,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic              sprite_hit,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue
);

  localparam int unsigned TickW  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned FrameW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam logic [10:0] SprW   = 11'(IMG_W << SCALE_LOG2);
  localparam logic [10:0] SprH   = 11'(IMG_H << SCALE_LOG2);
  localparam logic [ADDR_W-1:0] FrameSize = ADDR_W'(IMG_W * IMG_H);
  localparam logic [ADDR_W-1:0] RowSize   = ADDR_W'(IMG_W);

  logic [9:0]        r_sx, r_sy;
  logic              r_flip;
  logic [TickW-1:0]  r_tick;
  logic [FrameW-1:0] r_frame;

  // Shadow state: only vsync may change what the address math sees.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_sx    <= '0;
      r_sy    <= '0;
      r_flip  <= 1'b0;
      r_tick  <= '0;
      r_frame <= '0;
    end else if (vsync_pulse) begin
      r_sx   <= pos_x;
      r_sy   <= pos_y;
      r_flip <= flip_h;
      if (anim_en) begin
        if (r_tick == TickW'(FRAME_TICKS - 1)) begin
          r_tick  <= '0;
          r_frame <= (r_frame == FrameW'(NUM_FRAMES - 1)) ? '0 : r_frame + FrameW'(1);
        end else begin
          r_tick <= r_tick + TickW'(1);
        end
      end
    end
  end

  logic [10:0]       w_lx, w_ly, w_col, w_row;
  logic              w_in;
  logic [ADDR_W-1:0] w_addr;

  always_comb begin
    w_lx  = {1'b0, DrawX} - {1'b0, r_sx};
    w_ly  = {1'b0, DrawY} - {1'b0, r_sy};
    w_in  = (DrawX >= r_sx) && (DrawY >= r_sy) && (w_lx < SprW) && (w_ly < SprH);
    w_col = w_lx >> SCALE_LOG2;
    if (r_flip) w_col = 11'(IMG_W - 1) - w_col;
    w_row  = w_ly >> SCALE_LOG2;
    w_addr = '0;
    if (w_in) begin
      w_addr = ADDR_W'(r_frame) * FrameSize + ADDR_W'(w_row) * RowSize + ADDR_W'(w_col);
    end
  end

  logic              r_in1, r_blank1, r_in1b, r_blank1b, r_in2, r_blank2;
  logic [11:0]       r_bg1, r_bg1b, r_bg2;
  logic [ADDR_W-1:0] r_rom_address;
  logic [IDX_W-1:0]  r_pal_index;
  logic              r_hit;
  logic [11:0]       r_rgb;
  logic              w_opaque;

  assign w_opaque = r_in2 && (r_pal_index != IDX_W'(TRANSPARENT_IDX));

  // Stage 1b only aligns side-band data with the one-cycle ROM read.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_rom_address <= '0;
      r_in1         <= 1'b0;
      r_blank1      <= 1'b0;
      r_bg1         <= '0;
      r_in1b        <= 1'b0;
      r_blank1b     <= 1'b0;
      r_bg1b        <= '0;
      r_in2         <= 1'b0;
      r_blank2      <= 1'b0;
      r_bg2         <= '0;
      r_pal_index   <= '0;
      r_hit         <= 1'b0;
      r_rgb         <= '0;
    end else begin
      r_rom_address <= w_addr;
      r_in1         <= w_in;
      r_blank1      <= blank;
      r_bg1         <= {bg_red, bg_green, bg_blue};
      r_in1b        <= r_in1;
      r_blank1b     <= r_blank1;
      r_bg1b        <= r_bg1;
      r_pal_index   <= rom_q;
      r_in2         <= r_in1b;
      r_blank2      <= r_blank1b;
      r_bg2         <= r_bg1b;
      if (!r_blank2) begin
        r_hit <= 1'b0;
        r_rgb <= '0;
      end else if (w_opaque) begin
        r_hit <= 1'b1;
        r_rgb <= {pal_red, pal_green, pal_blue};
      end else begin
        r_hit <= 1'b0;
        r_rgb <= r_bg2;
      end
    end
  end

  assign rom_address = r_rom_address;
  assign pal_index   = r_pal_index;
  assign sprite_hit  = r_hit;
  assign red         = r_rgb[11:8];
  assign green       = r_rgb[7:4];
  assign blue        = r_rgb[3:0];

endmodule
